uart_rx_controller: RTL and testbench

Memory-mapped UART receiver that sits downstream of the uart_rx pin and upstream of the bus read mux. It feeds the bus's uart_ren/uart_out path.
- Deserialises 8N1 frames from uart_rx into a byte FIFO.
- Exposes a data register and a status register on data_addr[1:0].
- The CPU polls status and pops bytes by reading the data register.

---
 rtl/uart_rx_controller_pkg.sv | 27 ++
 rtl/uart_fifo.sv | 56 +++++
 rtl/uart_rx_controller.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_rx_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_controller_pkg.sv
// Shared definitions for the UART receive controller: register offsets, STATUS bit
// positions, RX state encoding and the baud divisor helper.
package uart_rx_controller_pkg;

    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;

    localparam int unsigned ST_RX_AVAIL  = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVERRUN   = 2;
    localparam int unsigned ST_FRAME_ERR = 3;
    localparam int unsigned ST_TX_BUSY   = 4;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO for the UART receiver; a push while full is accepted only when a pop
// frees a slot in the same cycle.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_count   = r_count;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// Memory-mapped 8N1 UART receiver with byte FIFO, DATA/STATUS registers.
// Optional transmitter enabled by defining UART_TX_EN.
module uart_rx_controller
    import uart_rx_controller_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 27000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ren,
    input  logic        wen,
    input  logic [1:0]  address,
    input  logic [31:0] data_in,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [31:0] data_out
);

    localparam int unsigned DIV       = baud_div(CLK_HZ, BAUD);
    localparam int unsigned CNT_W     = $clog2(DIV);
    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_SHOWN = (CW > 8) ? 8 : CW;
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(DIV - 1);

    logic [1:0]       r_sync;
    logic             w_rxs;
    rx_state_e        r_rx_state, w_rx_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shreg, w_shreg_nxt;
    logic             w_push;
    logic             w_frame_set;
    logic             w_overrun_set;
    logic             r_ren_q;
    logic             r_overrun, w_overrun_nxt;
    logic             r_frame_err, w_frame_err_nxt;
    logic             w_pop;
    logic             w_stat_rd;
    logic [7:0]       w_head;
    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_tx_busy;

    assign w_rxs = r_sync[1];

    always_ff @(posedge clk) begin
        if (reset) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], uart_rx};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shreg    <= '0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_shreg    <= w_shreg_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_cnt_nxt      = r_cnt;
        w_bit_nxt      = r_bit;
        w_shreg_nxt    = r_shreg;
        w_push         = 1'b0;
        w_frame_set    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (!w_rxs) begin
                    w_rx_state_nxt = RX_START;
                    w_cnt_nxt      = HALF_BIT;
                end
            end
            RX_START: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!w_rxs) begin
                    w_rx_state_nxt = RX_DATA;
                    w_cnt_nxt      = FULL_BIT;
                    w_bit_nxt      = '0;
                end else begin
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_shreg_nxt = {w_rxs, r_shreg[7:1]};
                    w_cnt_nxt   = FULL_BIT;
                    if (r_bit == 3'd7) w_rx_state_nxt = RX_STOP;
                    else               w_bit_nxt      = r_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_rxs) begin
                    w_push         = 1'b1;
                    w_rx_state_nxt = RX_IDLE;
                end else begin
                    w_frame_set    = 1'b1;
                    w_rx_state_nxt = RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (w_rxs) w_rx_state_nxt = RX_IDLE;
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // Read strobes fire once per ren assertion, on its rising edge.
    assign w_pop         = ren & ~r_ren_q & (address == UART_REG_DATA) & ~w_empty;
    assign w_stat_rd     = ren & ~r_ren_q & (address == UART_REG_STATUS);
    assign w_overrun_set = w_push & w_full & ~w_pop;

    always_comb begin
        w_overrun_nxt   = r_overrun;
        w_frame_err_nxt = r_frame_err;
        if (w_stat_rd) begin
            w_overrun_nxt   = 1'b0;
            w_frame_err_nxt = 1'b0;
        end
        if (w_overrun_set) w_overrun_nxt   = 1'b1;
        if (w_frame_set)   w_frame_err_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ren_q     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_ren_q     <= ren;
            r_overrun   <= w_overrun_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (r_shreg),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        data_out = '0;
        case (address)
            UART_REG_DATA: begin
                data_out[31]  = ~w_empty;
                data_out[7:0] = w_head;
            end
            UART_REG_STATUS: begin
                data_out[ST_RX_AVAIL]       = ~w_empty;
                data_out[ST_FULL]           = w_full;
                data_out[ST_OVERRUN]        = r_overrun;
                data_out[ST_FRAME_ERR]      = r_frame_err;
                data_out[ST_TX_BUSY]        = w_tx_busy;
                data_out[8 +: CNT_SHOWN]    = w_count[CNT_SHOWN-1:0];
            end
            default: data_out = '0;
        endcase
    end

`ifdef UART_TX_EN
    logic             r_wen_q;
    logic             r_tx_busy, w_tx_busy_nxt;
    logic [9:0]       r_tx_sh, w_tx_sh_nxt;
    logic [3:0]       r_tx_bits, w_tx_bits_nxt;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic             w_tx_load;
    logic             w_unused;

    assign w_unused  = ^data_in[31:8];
    assign w_tx_load = wen & ~r_wen_q & (address == UART_REG_DATA) & ~r_tx_busy;
    assign w_tx_busy = r_tx_busy;
    // Shifter refills with ones, so bit 0 idles high once the frame is out.
    assign uart_tx   = r_tx_sh[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wen_q   <= 1'b0;
            r_tx_busy <= 1'b0;
            r_tx_sh   <= '1;
            r_tx_bits <= '0;
            r_tx_cnt  <= '0;
        end else begin
            r_wen_q   <= wen;
            r_tx_busy <= w_tx_busy_nxt;
            r_tx_sh   <= w_tx_sh_nxt;
            r_tx_bits <= w_tx_bits_nxt;
            r_tx_cnt  <= w_tx_cnt_nxt;
        end
    end

    always_comb begin
        w_tx_busy_nxt = r_tx_busy;
        w_tx_sh_nxt   = r_tx_sh;
        w_tx_bits_nxt = r_tx_bits;
        w_tx_cnt_nxt  = r_tx_cnt;
        if (!r_tx_busy) begin
            if (w_tx_load) begin
                w_tx_busy_nxt = 1'b1;
                w_tx_sh_nxt   = {1'b1, data_in[7:0], 1'b0};
                w_tx_bits_nxt = 4'd9;
                w_tx_cnt_nxt  = FULL_BIT;
            end
        end else if (r_tx_cnt != '0) begin
            w_tx_cnt_nxt = r_tx_cnt - 1'b1;
        end else if (r_tx_bits == 4'd0) begin
            w_tx_busy_nxt = 1'b0;
        end else begin
            w_tx_sh_nxt   = {1'b1, r_tx_sh[9:1]};
            w_tx_bits_nxt = r_tx_bits - 4'd1;
            w_tx_cnt_nxt  = FULL_BIT;
        end
    end
`else
    logic w_unused;

    assign w_unused  = ^{wen, data_in};
    assign w_tx_busy = 1'b0;
    assign uart_tx   = 1'b1;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed self-checking bench for uart_rx_controller at DIV=10 (1 MHz clock, 100 kbaud).
module tb_uart_rx_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [31:0] data_in = '0;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic [31:0] data_out;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] rd;
    logic [7:0]  tx_exp;

    uart_rx_controller #(
        .CLK_HZ     (1000000),
        .BAUD       (100000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ren      (ren),
        .wen      (wen),
        .address  (address),
        .data_in  (data_in),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(10);
        end
        uart_rx = stop;
        tick(10);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        ren     = 1'b1;
        #1 d    = data_out;
        tick(1);
        ren = 1'b0;
        tick(1);
    endtask

    task automatic bus_write(input logic [7:0] b);
        address = 2'd0;
        data_in = {24'h0, b};
        wen     = 1'b1;
        tick(1);
        wen = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick(3);
        reset = 1'b0;
        tick(2);
        bus_read(2'd1, rd);
        check("reset_status", rd, 32'h0);
        bus_read(2'd0, rd);
        check("reset_data", rd, 32'h0);
        check("reset_tx", {31'h0, uart_tx}, 32'h1);
        bus_read(2'd2, rd);
        check("addr2_zero", rd, 32'h0);

        // Single frame, then pop.
        send_frame(8'h5A, 1'b1);
        tick(2);
        bus_read(2'd1, rd);
        check("5a_status", rd, 32'h0000_0101);
        bus_read(2'd0, rd);
        check("5a_data", rd, 32'h8000_005A);
        bus_read(2'd1, rd);
        check("5a_status_after", rd, 32'h0);

        // Long ren pulse pops once.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(2);
        address = 2'd0;
        ren     = 1'b1;
        #1 check("hold_head", data_out, 32'h8000_0011);
        tick(5);
        ren = 1'b0;
        tick(1);
        bus_read(2'd1, rd);
        check("hold_status", rd, 32'h0000_0101);
        bus_read(2'd0, rd);
        check("hold_data2", rd, 32'h8000_0022);

        // Overflow: 17 frames into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        tick(2);
        bus_read(2'd1, rd);
        check("ovr_status", rd, 32'h0000_1007);
        bus_read(2'd1, rd);
        check("ovr_cleared", rd, 32'h0000_1003);
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, rd);
            check($sformatf("ovr_pop%0d", i), rd, 32'h8000_0000 | 32'(i));
        end
        bus_read(2'd1, rd);
        check("ovr_drained", rd, 32'h0);

        // Framing error with line held low, then recovery.
        send_frame(8'hA5, 1'b0);
        tick(20);
        bus_read(2'd1, rd);
        check("ferr_status", rd, 32'h0000_0008);
        uart_rx = 1'b1;
        tick(100);
        bus_read(2'd1, rd);
        check("ferr_break_nopush", rd, 32'h0);
        send_frame(8'h3C, 1'b1);
        tick(2);
        bus_read(2'd0, rd);
        check("ferr_next_data", rd, 32'h8000_003C);

        // Start-bit glitch.
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(20);
        bus_read(2'd1, rd);
        check("glitch_status", rd, 32'h0);

        // Reset in the middle of a frame.
        uart_rx = 1'b0;
        tick(10);
        uart_rx = 1'b1;
        tick(10);
        uart_rx = 1'b1;
        tick(10);
        uart_rx = 1'b1;
        reset   = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(20);
        bus_read(2'd1, rd);
        check("midrst_status", rd, 32'h0);
        send_frame(8'h66, 1'b1);
        tick(2);
        bus_read(2'd0, rd);
        check("midrst_next_data", rd, 32'h8000_0066);

`ifdef UART_TX_EN
        // Frame 0xC3: start, 1,1,0,0,0,0,1,1, stop.
        tx_exp = 8'hC3;
        bus_write(8'hC3);
        tick(4);
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      check("tx_start", {31'h0, uart_tx}, 32'h0);
            else if (k == 9) check("tx_stop", {31'h0, uart_tx}, 32'h1);
            else check($sformatf("tx_bit%0d", k - 1), {31'h0, uart_tx}, {31'h0, tx_exp[k-1]});
            if (k == 2) begin
                bus_write(8'hFF);
                tick(9);
            end else if (k == 5) begin
                address = 2'd1;
                #1 check("tx_busy_mid", {31'h0, data_out[4]}, 32'h1);
                tick(10);
            end else begin
                tick(10);
            end
        end
        address = 2'd1;
        #1 check("tx_busy_done", {31'h0, data_out[4]}, 32'h0);
        tick(30);
        check("tx_idle_after", {31'h0, uart_tx}, 32'h1);
`else
        bus_write(8'hC3);
        for (int k = 0; k < 4; k++) begin
            tick(10);
            check($sformatf("notx_line%0d", k), {31'h0, uart_tx}, 32'h1);
        end
        address = 2'd1;
        #1 check("notx_busy", {31'h0, data_out[4]}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
